// File: rtl/cpu_pkg.sv
// Shared CPU definitions: branch types, ARM condition codes, branch-resolve
// FSM states and NZCV bit positions.
package cpu_pkg;

   typedef enum logic [2:0] {
      BR_NONE  = 3'd0,
      BR_B     = 3'd1,
      BR_CBZ   = 3'd2,
      BR_CBNZ  = 3'd3,
      BR_BCOND = 3'd4
   } br_type_e;

   typedef enum logic [3:0] {
      EQ, NE, CS, CC, MI, PL, VS, VC,
      HI, LS, GE, LT, GT, LE, AL, NV
   } cond_e;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      FLUSH
   } brc_state_e;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_eval.sv
// ARM condition-code evaluator: decides whether a B.cond passes for a given
// NZCV value. Purely combinational.
module cond_eval
   import cpu_pkg::*;
(
   input  logic [3:0] cond_i,
   input  logic [3:0] nzcv_i,
   output logic       pass_o
);

   logic n, z, c, v;

   assign n = nzcv_i[FLAG_N];
   assign z = nzcv_i[FLAG_Z];
   assign c = nzcv_i[FLAG_C];
   assign v = nzcv_i[FLAG_V];

   always_comb begin
      pass_o = 1'b0;
      case (cond_e'(cond_i))
         EQ: pass_o = z;
         NE: pass_o = ~z;
         CS: pass_o = c;
         CC: pass_o = ~c;
         MI: pass_o = n;
         PL: pass_o = ~n;
         VS: pass_o = v;
         VC: pass_o = ~v;
         HI: pass_o = c & ~z;
         LS: pass_o = ~c | z;
         GE: pass_o = (n == v);
         LT: pass_o = (n != v);
         GT: pass_o = ~z & (n == v);
         LE: pass_o = z | (n != v);
         AL: pass_o = 1'b1;
         NV: pass_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// ID-stage branch resolution: owns NZCV, forwards flags from EX, stalls on
// pending multi-cycle flag producers, flushes on taken branches, counts branches.
module branch_resolve_ctrl
   import cpu_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ex_valid,
   input  logic             ex_set_flags,
   input  logic             ex_flags_rdy,
   input  logic [WIDTH-1:0] ex_result,
   input  logic             ex_carry,
   input  logic             ex_overflow,
   input  logic             id_valid,
   input  logic [2:0]       id_br_type,
   input  logic [3:0]       id_cond,
   input  logic [WIDTH-1:0] id_cbz_val,
   output logic             stall_id,
   output logic             br_taken,
   output logic             flush_if,
   output logic             id_kill,
   output logic [3:0]       flags_q,
   output logic [CNT_W-1:0] br_count,
   output logic [CNT_W-1:0] taken_count
);

   brc_state_e       state_q, state_d;
   logic [CNT_W-1:0] brCnt_q, takenCnt_q;
   logic [3:0]       exFlags, effFlags;
   logic             flagWrite, flagsPending, isBranch, isBcond;
   logic             condPass, takenSel, resolve, stallId, brTaken, idKill;

   assign exFlags      = {ex_result[WIDTH-1], ~|ex_result, ex_carry, ex_overflow};
   assign flagWrite    = ex_valid & ex_set_flags & ex_flags_rdy;
   assign flagsPending = ex_valid & ex_set_flags & ~ex_flags_rdy;
   assign effFlags     = flagWrite ? exFlags : flags_q;
   assign isBranch     = id_valid && (id_br_type != BR_NONE) && (id_br_type <= BR_BCOND);
   assign isBcond      = (id_br_type == BR_BCOND);

   cond_eval uCondEval (
      .cond_i (id_cond),
      .nzcv_i (effFlags),
      .pass_o (condPass)
   );

   always_comb begin
      takenSel = 1'b0;
      case (br_type_e'(id_br_type))
         BR_B:     takenSel = 1'b1;
         BR_CBZ:   takenSel = (id_cbz_val == '0);
         BR_CBNZ:  takenSel = (id_cbz_val != '0);
         BR_BCOND: takenSel = condPass;
         default:  takenSel = 1'b0;
      endcase
   end

   // WAIT resolves as soon as nothing is pending, which also covers EX dropping
   // its instruction: effFlags then falls back to flags_q.
   always_comb begin
      state_d = state_q;
      stallId = 1'b0;
      idKill  = 1'b0;
      resolve = 1'b0;
      brTaken = 1'b0;
      case (state_q)
         IDLE: begin
            if (isBranch) begin
               if (isBcond && flagsPending) begin
                  stallId = 1'b1;
                  state_d = WAIT;
               end else begin
                  resolve = 1'b1;
               end
            end
         end
         WAIT: begin
            if (flagsPending) begin
               stallId = 1'b1;
            end else if (isBranch) begin
               resolve = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         FLUSH: begin
            idKill  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (resolve) begin
         brTaken = takenSel;
         state_d = takenSel ? FLUSH : IDLE;
      end
   end

   // Gated by rst_n so that asserting reset clears the outputs at once, even
   // while ID still presents a branch.
   assign stall_id    = rst_n & stallId;
   assign br_taken    = rst_n & brTaken;
   assign flush_if    = rst_n & brTaken;
   assign id_kill     = rst_n & idKill;
   assign br_count    = brCnt_q;
   assign taken_count = takenCnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         flags_q    <= 4'b0000;
         brCnt_q    <= '0;
         takenCnt_q <= '0;
      end else begin
         state_q <= state_d;
         if (flagWrite) begin
            flags_q <= exFlags;
         end
         if (resolve && (brCnt_q != '1)) begin
            brCnt_q <= brCnt_q + CNT_W'(1);
         end
         if (resolve && takenSel && (takenCnt_q != '1)) begin
            takenCnt_q <= takenCnt_q + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed self-checking bench for branch_resolve_ctrl; counters are narrowed
// to 4 bits so saturation is reachable in a few cycles.
module tb_branch_resolve_ctrl;
   import cpu_pkg::*;

   localparam int WIDTH = 64;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             ex_valid, ex_set_flags, ex_flags_rdy, ex_carry, ex_overflow;
   logic [WIDTH-1:0] ex_result, id_cbz_val;
   logic             id_valid;
   logic [2:0]       id_br_type;
   logic [3:0]       id_cond;
   logic             stall_id, br_taken, flush_if, id_kill;
   logic [3:0]       flags_q;
   logic [CNT_W-1:0] br_count, taken_count;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   branch_resolve_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ex_valid     (ex_valid),
      .ex_set_flags (ex_set_flags),
      .ex_flags_rdy (ex_flags_rdy),
      .ex_result    (ex_result),
      .ex_carry     (ex_carry),
      .ex_overflow  (ex_overflow),
      .id_valid     (id_valid),
      .id_br_type   (id_br_type),
      .id_cond      (id_cond),
      .id_cbz_val   (id_cbz_val),
      .stall_id     (stall_id),
      .br_taken     (br_taken),
      .flush_if     (flush_if),
      .id_kill      (id_kill),
      .flags_q      (flags_q),
      .br_count     (br_count),
      .taken_count  (taken_count)
   );

   task automatic applyStimulus(input logic exV, input logic exS, input logic exR,
                                input logic [WIDTH-1:0] res, input logic c, input logic v,
                                input logic idV, input logic [2:0] typ,
                                input logic [3:0] cond, input logic [WIDTH-1:0] cbz);
      ex_valid     = exV;
      ex_set_flags = exS;
      ex_flags_rdy = exR;
      ex_result    = res;
      ex_carry     = c;
      ex_overflow  = v;
      id_valid     = idV;
      id_br_type   = typ;
      id_cond      = cond;
      id_cbz_val   = cbz;
      #1;
   endtask

   task automatic applyIdle();
      applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, BR_NONE, 4'd0, '0);
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   function automatic logic condModel(input logic [3:0] cond, input logic [3:0] f);
      logic n, z, c, v;
      {n, z, c, v} = f;
      case (cond)
         4'd0:  return z;
         4'd1:  return !z;
         4'd2:  return c;
         4'd3:  return !c;
         4'd4:  return n;
         4'd5:  return !n;
         4'd6:  return v;
         4'd7:  return !v;
         4'd8:  return c && !z;
         4'd9:  return !c || z;
         4'd10: return n == v;
         4'd11: return n != v;
         4'd12: return !z && (n == v);
         4'd13: return z || (n != v);
         default: return 1'b1;
      endcase
   endfunction

   initial begin
      logic [WIDTH-1:0] res;
      logic             exp;

      rst_n = 1'b0;
      applyIdle();
      checkOutput("rst_flags", flags_q, 4'b0000);
      checkOutput("rst_brcnt", br_count, 0);
      checkOutput("rst_takencnt", taken_count, 0);
      checkOutput("rst_stall", stall_id, 0);
      checkOutput("rst_taken", br_taken, 0);
      checkOutput("rst_kill", id_kill, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // SUBS result 0, C=1 forwarded to a B.EQ in the same cycle
      applyStimulus(1, 1, 1, '0, 1, 0, 1, BR_BCOND, 4'd0, '0);
      checkOutput("beq_taken", br_taken, 1);
      checkOutput("beq_flush", flush_if, 1);
      checkOutput("beq_stall", stall_id, 0);
      nextCycle();
      applyStimulus(0, 0, 0, '0, 0, 0, 1, BR_B, 4'd0, '0);
      checkOutput("beq_kill", id_kill, 1);
      checkOutput("flush_ignores_id", br_taken, 0);
      checkOutput("beq_flags", flags_q, 4'b0110);
      nextCycle();
      applyIdle();
      checkOutput("beq_kill_off", id_kill, 0);
      checkOutput("beq_brcnt", br_count, 1);
      checkOutput("beq_takencnt", taken_count, 1);

      // Multi-cycle flag producer with B.MI waiting, MSB=1 then MSB=0
      for (int pass = 0; pass < 2; pass++) begin
         for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 1, 0, '0, 0, 0, 1, BR_BCOND, 4'd4, '0);
            checkOutput($sformatf("bmi%0d_stall%0d", pass, i), stall_id, 1);
            checkOutput($sformatf("bmi%0d_notyet%0d", pass, i), br_taken, 0);
            nextCycle();
         end
         res = (pass == 0) ? 64'h8000_0000_0000_0000 : 64'h1;
         applyStimulus(1, 1, 1, res, 0, 0, 1, BR_BCOND, 4'd4, '0);
         checkOutput($sformatf("bmi%0d_stall_rdy", pass), stall_id, 0);
         checkOutput($sformatf("bmi%0d_taken", pass), br_taken, (pass == 0) ? 1 : 0);
         nextCycle();
         applyIdle();
         checkOutput($sformatf("bmi%0d_kill", pass), id_kill, (pass == 0) ? 1 : 0);
         nextCycle();
      end
      checkOutput("bmi_flags", flags_q, 4'b0000);
      checkOutput("bmi_brcnt", br_count, 3);
      checkOutput("bmi_takencnt", taken_count, 2);

      // CBZ / CBNZ do not touch flags
      applyStimulus(0, 0, 0, '0, 0, 0, 1, BR_CBZ, 4'd0, 64'h0);
      checkOutput("cbz0_taken", br_taken, 1);
      nextCycle();
      applyIdle();
      nextCycle();
      applyStimulus(0, 0, 0, '0, 0, 0, 1, BR_CBNZ, 4'd0, 64'h8000_0000_0000_0000);
      checkOutput("cbnz_msb_taken", br_taken, 1);
      nextCycle();
      applyIdle();
      nextCycle();
      applyStimulus(0, 0, 0, '0, 0, 0, 1, BR_CBZ, 4'd0, 64'h1);
      checkOutput("cbz1_taken", br_taken, 0);
      nextCycle();
      applyIdle();
      checkOutput("cbz1_kill", id_kill, 0);
      checkOutput("cbz_flags", flags_q, 4'b0000);
      checkOutput("cbz_brcnt", br_count, 6);
      checkOutput("cbz_takencnt", taken_count, 4);

      // Condition sweep over every NZCV an ALU result can produce (N and Z never both set)
      for (int f = 0; f < 16; f++) begin
         if (f[3] && f[2]) continue;
         res = f[2] ? 64'h0 : (f[3] ? 64'h8000_0000_0000_0000 : 64'h1);
         for (int cnd = 0; cnd < 16; cnd++) begin
            applyStimulus(1, 1, 1, res, f[1], f[0], 1, BR_BCOND, 4'(cnd), '0);
            exp = condModel(4'(cnd), 4'(f));
            checkOutput($sformatf("cond%0d_nzcv%0h", cnd, f), br_taken, exp);
            nextCycle();
            if (exp) begin
               applyIdle();
               nextCycle();
            end
         end
      end
      checkOutput("sweep_flags", flags_q, 4'b1011);

      // Reset asserted while waiting on pending flags
      applyStimulus(1, 1, 0, '0, 0, 0, 1, BR_BCOND, 4'd0, '0);
      checkOutput("wait_enter_stall", stall_id, 1);
      nextCycle();
      checkOutput("wait_stall", stall_id, 1);
      rst_n = 1'b0;
      #1;
      checkOutput("wait_rst_stall", stall_id, 0);
      checkOutput("wait_rst_taken", br_taken, 0);
      checkOutput("wait_rst_flags", flags_q, 4'b0000);
      checkOutput("wait_rst_brcnt", br_count, 0);
      checkOutput("wait_rst_takencnt", taken_count, 0);
      applyIdle();
      @(posedge clk);
      #1 rst_n = 1'b1;
      applyStimulus(0, 0, 0, '0, 0, 0, 1, BR_B, 4'd0, '0);
      checkOutput("post_rst_b_taken", br_taken, 1);
      nextCycle();
      applyIdle();
      checkOutput("post_rst_b_kill", id_kill, 1);
      nextCycle();
      checkOutput("post_rst_brcnt", br_count, 1);

      // Saturation: 13 not-taken branches bring br_count to 14, then 3 more
      for (int i = 0; i < 13; i++) begin
         applyStimulus(0, 0, 0, '0, 0, 0, 1, BR_CBZ, 4'd0, 64'h1);
         nextCycle();
      end
      checkOutput("sat_pre", br_count, 14);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0, 0, '0, 0, 0, 1, BR_CBZ, 4'd0, 64'h1);
         nextCycle();
         checkOutput($sformatf("sat_hold%0d", i), br_count, 15);
      end
      checkOutput("sat_takencnt", taken_count, 1);
      applyIdle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
